// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex display driver with a double-buffered value and spinner mode.
// Optional leading-zero suppression is compiled in when SEVEN_SEG_LZ_SUPPRESS_EN is defined.
module seven_seg_scan #(
    parameter int N_DIGITS   = 4,
    parameter int PRESCALE   = 1024,
    parameter int ANIM_DIV   = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*N_DIGITS-1:0] value_in,
    input  logic                  load_in,
    input  logic [N_DIGITS-1:0]   blank_mask_in,
    input  logic                  anim_en_in,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   dig_sel_out,
    output logic                  frame_tick_out
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [7:0]          SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [AW-1:0]         anim_cnt;
    logic [2:0]            phase;
    logic [5*N_DIGITS-1:0] shadow;
    logic [5*N_DIGITS-1:0] active;
    logic                  pending;

    logic                  tc;
    logic                  last_idx;
    logic                  wrap;
    logic                  anim_last;
    logic [N_DIGITS-1:0]   lz;
    logic                  lz_run;
    logic [4:0]            cur;
    logic                  cur_blank;
    logic                  cur_lz;
    logic [7:0]            seg_next;
    logic [N_DIGITS-1:0]   dig_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tc        = (presc == PW'(PRESCALE - 1));
    assign last_idx  = (idx == IW'(N_DIGITS - 1));
    assign wrap      = tc && last_idx;
    assign anim_last = (anim_cnt == AW'(ANIM_DIV - 1));

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    // A digit is a leading zero only while every digit above it is also blank-worthy.
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int d = N_DIGITS - 1; d >= 1; d--) begin
            lz_run = lz_run && (active[5*d +: 5] == 5'd0);
            lz[d]  = lz_run;
        end
    end
`else
    assign lz     = '0;
    assign lz_run = 1'b0;
`endif

    always_comb begin
        cur       = '0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        dig_next  = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (idx == IW'(d)) begin
                cur         = active[5*d +: 5];
                cur_blank   = blank_mask_in[d];
                cur_lz      = lz[d];
                dig_next[d] = 1'b1;
            end
        end
        if (cur_blank || (!anim_en_in && cur_lz))
            seg_next = 8'h00;
        else if (anim_en_in)
            seg_next = 8'h01 << phase;
        else
            seg_next = {cur[4], hex_decode(cur[3:0])};
    end

    // Segment and select registers share one edge so the bus never mixes two digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc          <= '0;
            idx            <= '0;
            anim_cnt       <= '0;
            phase          <= '0;
            shadow         <= '0;
            active         <= '0;
            pending        <= 1'b0;
            seg_out        <= SEG_OFF;
            dig_sel_out    <= DIG_OFF;
            frame_tick_out <= 1'b0;
        end else begin
            seg_out        <= seg_next ^ SEG_OFF;
            dig_sel_out    <= dig_next ^ DIG_OFF;
            frame_tick_out <= wrap;

            if (tc) begin
                presc <= '0;
                idx   <= last_idx ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            if (load_in && wrap) begin
                shadow  <= value_in;
                active  <= value_in;
                pending <= 1'b0;
            end else if (load_in) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end else if (wrap && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end

            if (!anim_en_in) begin
                anim_cnt <= '0;
                phase    <= '0;
            end else if (wrap) begin
                if (anim_last) begin
                    anim_cnt <= '0;
                    phase    <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                end else begin
                    anim_cnt <= anim_cnt + AW'(1);
                end
            end
        end
    end
endmodule
